jtag_shifter: RTL and testbench

JTAG_SHIFTER -- requirements
Module: jtag_shifter

---
 rtl/jtag_shifter.sv | 134 +++++++++++++
 tb/tb_jtag_shifter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shifter.sv
// jtag_shifter: shifts up to 8 TDI bits (LSB first) onto a JTAG port and returns the sampled TDO bits.
// Latency: 2*CLKDIV*n CLK cycles from the first LOW cycle to the response for an n-bit command.
// Backpressure: CMD_READY is low while a command or an unconsumed response is outstanding; RESP holds until RSP_READY.
// Ports: CLK/RST; CMD_VALID/CMD_READY/CMD_DATA/CMD_LEN/CMD_TMS/CMD_TMS_LAST command side;
//        RSP_VALID/RSP_READY/RSP_DATA response side; TCK/TDI/TMS/TDO JTAG pins; BUSY status.
module jtag_shifter #(
  parameter int CLKDIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [7:0] CMD_DATA,
  input  logic [2:0] CMD_LEN,
  input  logic       CMD_TMS,
  input  logic       CMD_TMS_LAST,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic       TCK,
  output logic       TDI,
  output logic       TMS,
  input  logic       TDO,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_RESP
  } state_t;

  // Each LOW/HIGH phase lasts RELOAD+1 = CLKDIV cycles.
  localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic [2:0] r_len;
  logic [7:0] r_data;
  logic       r_tms;
  logic       r_tms_last;

  logic [2:0] w_next_bit;
  assign w_next_bit = r_bit + 3'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_bit      <= 3'd0;
      r_len      <= 3'd0;
      r_data     <= 8'd0;
      r_tms      <= 1'b0;
      r_tms_last <= 1'b0;
      TCK        <= 1'b0;
      TDI        <= 1'b0;
      TMS        <= 1'b1;
      RSP_VALID  <= 1'b0;
      RSP_DATA   <= 8'd0;
      CMD_READY  <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            r_data     <= CMD_DATA;
            r_len      <= CMD_LEN;
            r_tms      <= CMD_TMS;
            r_tms_last <= CMD_TMS_LAST;
            r_bit      <= 3'd0;
            r_cnt      <= RELOAD;
            RSP_DATA   <= 8'd0;
            TDI        <= CMD_DATA[0];
            // A 1-bit command's only bit is also its last bit.
            TMS        <= (CMD_LEN == 3'd0) ? CMD_TMS_LAST : CMD_TMS;
            CMD_READY  <= 1'b0;
            BUSY       <= 1'b1;
            r_state    <= S_LOW;
          end else begin
            // Also raises READY on the first edge out of reset.
            CMD_READY <= 1'b1;
          end
        end

        S_LOW: begin
          if (r_cnt == 8'd0) begin
            TCK             <= 1'b1;
            RSP_DATA[r_bit] <= TDO;
            r_cnt           <= RELOAD;
            r_state         <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_HIGH: begin
          if (r_cnt == 8'd0) begin
            TCK   <= 1'b0;
            r_cnt <= RELOAD;
            if (r_bit != r_len) begin
              // Next bit is presented on the falling edge only.
              r_bit   <= w_next_bit;
              TDI     <= r_data[w_next_bit];
              TMS     <= (w_next_bit == r_len) ? r_tms_last : r_tms;
              r_state <= S_LOW;
            end else begin
              // TDI/TMS keep the last-bit values until the next command.
              RSP_VALID <= 1'b1;
              r_state   <= S_RESP;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_RESP: begin
          // RSP_VALID is always high here, so RSP_READY alone completes the handshake.
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            BUSY      <= 1'b0;
            // Ready on IDLE entry so a waiting command starts one cycle later.
            CMD_READY <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_shifter.sv
// tb_jtag_shifter: randomized self-checking bench for jtag_shifter (instance A CLKDIV=4, instance B CLKDIV=1).
// Latency: checks 2*CLKDIV*n cycles per command against a bit-level reference model.
// Backpressure: exercises RSP_READY hold-off, early RSP_READY and back-to-back commands.
module tb_jtag_shifter;

  logic clk;
  logic rst;

  logic       a_cmd_valid, a_cmd_ready, a_cmd_tms, a_cmd_tms_last;
  logic [7:0] a_cmd_data;
  logic [2:0] a_cmd_len;
  logic       a_rsp_valid, a_rsp_ready;
  logic [7:0] a_rsp_data;
  logic       a_tck, a_tdi, a_tms, a_tdo, a_busy;

  logic       b_cmd_valid, b_cmd_ready, b_cmd_tms, b_cmd_tms_last;
  logic [7:0] b_cmd_data;
  logic [2:0] b_cmd_len;
  logic       b_rsp_valid, b_rsp_ready;
  logic [7:0] b_rsp_data;
  logic       b_tck, b_tdi, b_tms, b_tdo, b_busy;

  int n_checks = 0;
  int n_errors = 0;

  jtag_shifter #(.CLKDIV(4)) u_dut_a (
    .CLK(clk), .RST(rst),
    .CMD_VALID(a_cmd_valid), .CMD_READY(a_cmd_ready), .CMD_DATA(a_cmd_data),
    .CMD_LEN(a_cmd_len), .CMD_TMS(a_cmd_tms), .CMD_TMS_LAST(a_cmd_tms_last),
    .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready), .RSP_DATA(a_rsp_data),
    .TCK(a_tck), .TDI(a_tdi), .TMS(a_tms), .TDO(a_tdo), .BUSY(a_busy)
  );

  jtag_shifter #(.CLKDIV(1)) u_dut_b (
    .CLK(clk), .RST(rst),
    .CMD_VALID(b_cmd_valid), .CMD_READY(b_cmd_ready), .CMD_DATA(b_cmd_data),
    .CMD_LEN(b_cmd_len), .CMD_TMS(b_cmd_tms), .CMD_TMS_LAST(b_cmd_tms_last),
    .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready), .RSP_DATA(b_rsp_data),
    .TCK(b_tck), .TDI(b_tdi), .TMS(b_tms), .TDO(b_tdo), .BUSY(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Runs one command on instance A and checks pins, timing and response against the model.
  task automatic run_cmd(input logic [7:0] data, input logic [2:0] len, input logic tms,
                         input logic tms_last, input logic [7:0] pat, input bit loop,
                         input int hold, input bit early);
    int n, nrise, cyc, bad, hbad;
    bit ok, seen;
    logic prev_tck, prev_tdi, prev_tms;
    logic [7:0] mask, exp_tdi, exp_tms, exp_rsp, got_tdi, got_tms;
    n = int'(len) + 1;
    mask = 8'd0; exp_tms = 8'd0;
    for (int i = 0; i < n; i++) begin
      mask[i] = 1'b1;
      exp_tms[i] = (i == n - 1) ? tms_last : tms;
    end
    exp_tdi = data & mask;
    exp_rsp = loop ? (data & mask) : (pat & mask);

    @(negedge clk);
    a_cmd_data = data; a_cmd_len = len; a_cmd_tms = tms; a_cmd_tms_last = tms_last;
    a_cmd_valid = 1'b1; a_rsp_ready = early;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (a_cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_errors++; $display("FAIL accept_wait: cmd_ready got %b required 1", ok);
      a_cmd_valid = 1'b0; return;
    end
    @(posedge clk); #1;
    // In-flight command must ignore these.
    a_cmd_data = ~data; a_cmd_len = ~len; a_cmd_tms = ~tms; a_cmd_tms_last = ~tms_last;
    a_cmd_valid = 1'b0;

    nrise = 0; bad = 0; seen = 1'b0; got_tdi = 8'd0; got_tms = 8'd0;
    prev_tck = 1'b0; prev_tdi = a_tdi; prev_tms = a_tms;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (a_rsp_valid) begin seen = 1'b1; break; end
      if (a_tck && !prev_tck && nrise < 8) begin
        got_tdi[nrise] = a_tdi; got_tms[nrise] = a_tms; nrise++;
      end
      if (a_tck && prev_tck && (a_tdi !== prev_tdi || a_tms !== prev_tms)) bad++;
      if (!a_tck) a_tdo = loop ? a_tdi : ((nrise < 8) ? pat[nrise] : 1'b0);
      prev_tck = a_tck; prev_tdi = a_tdi; prev_tms = a_tms;
    end

    n_checks++;
    if (seen !== 1'b1) begin n_errors++; $display("FAIL rsp_timeout: rsp_valid got %b required 1", seen); end
    n_checks++;
    if (cyc !== 2 * 4 * n + 1) begin n_errors++; $display("FAIL cmd_cycles: got %0d required %0d", cyc - 1, 2 * 4 * n); end
    n_checks++;
    if (nrise !== n) begin n_errors++; $display("FAIL tck_pulses: got %0d required %0d", nrise, n); end
    n_checks++;
    if (got_tdi !== exp_tdi) begin n_errors++; $display("FAIL tdi_seq: got %h required %h", got_tdi, exp_tdi); end
    n_checks++;
    if (got_tms !== exp_tms) begin n_errors++; $display("FAIL tms_seq: got %h required %h", got_tms, exp_tms); end
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL tdi_tms_stable_high: got %0d changes required 0", bad); end
    n_checks++;
    if (a_rsp_data !== exp_rsp) begin n_errors++; $display("FAIL rsp_data: got %h required %h", a_rsp_data, exp_rsp); end
    n_checks++;
    if ({a_busy, a_cmd_ready, a_tck} !== 3'b100) begin
      n_errors++; $display("FAIL resp_status: busy/ready/tck got %b required 100", {a_busy, a_cmd_ready, a_tck});
    end

    if (!early && hold > 0) begin
      hbad = 0;
      a_cmd_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!a_rsp_valid || a_rsp_data !== exp_rsp || a_cmd_ready || !a_busy) hbad++;
      end
      a_cmd_valid = 1'b0;
      n_checks++;
      if (hbad !== 0) begin n_errors++; $display("FAIL rsp_hold: got %0d bad cycles required 0", hbad); end
    end

    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    n_checks++;
    if ({a_rsp_valid, a_busy, a_cmd_ready, a_tck, a_tdi, a_tms} !== {4'b0010, data[len], tms_last}) begin
      n_errors++;
      $display("FAIL after_resp: vld/busy/rdy/tck/tdi/tms got %b required %b",
               {a_rsp_valid, a_busy, a_cmd_ready, a_tck, a_tdi, a_tms}, {4'b0010, data[len], tms_last});
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({a_rsp_valid, a_tck, a_tdi, a_tms} !== {2'b00, data[len], tms_last}) begin
      n_errors++;
      $display("FAIL idle_hold: vld/tck/tdi/tms got %b required %b",
               {a_rsp_valid, a_tck, a_tdi, a_tms}, {2'b00, data[len], tms_last});
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_tck, a_tdi, a_tms, a_rsp_valid, a_cmd_ready, a_busy, a_rsp_data} !== {6'b001000, 8'h00}) begin
      n_errors++; $display("FAIL reset_a: got %b required %b",
        {a_tck, a_tdi, a_tms, a_rsp_valid, a_cmd_ready, a_busy, a_rsp_data}, {6'b001000, 8'h00});
    end
    n_checks++;
    if ({b_tck, b_tdi, b_tms, b_rsp_valid, b_cmd_ready, b_busy, b_rsp_data} !== {6'b001000, 8'h00}) begin
      n_errors++; $display("FAIL reset_b: got %b required %b",
        {b_tck, b_tdi, b_tms, b_rsp_valid, b_cmd_ready, b_busy, b_rsp_data}, {6'b001000, 8'h00});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_cmd_ready, b_cmd_ready} !== 2'b11) begin
      n_errors++; $display("FAIL ready_after_reset: got %b required 11", {a_cmd_ready, b_cmd_ready});
    end
  endtask

  task automatic test_loopback;
    run_cmd(8'hA5, 3'd7, 1'b0, 1'b1, 8'h00, 1'b1, 0, 1'b0);
  endtask

  task automatic test_single_bit;
    logic t;
    t = 1'($urandom);
    run_cmd(8'h01, 3'd0, t, ~t, 8'hFF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_len2;
    run_cmd(8'($urandom), 3'd2, 1'b1, 1'b0, 8'hFF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++)
      run_cmd(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
              1'b0, 0, 1'(k & 1));
  endtask

  task automatic test_rsp_hold;
    run_cmd(8'($urandom), 3'd5, 1'b0, 1'b1, 8'($urandom), 1'b0, 20, 1'b0);
  endtask

  task automatic test_reset_abort;
    int nrise, vbad;
    bit hit;
    logic prev_tck;
    @(negedge clk);
    a_cmd_data = 8'hFF; a_cmd_len = 3'd7; a_cmd_tms = 1'b0; a_cmd_tms_last = 1'b0;
    a_cmd_valid = 1'b1; a_tdo = 1'b1; a_rsp_ready = 1'b1;
    nrise = 0; hit = 1'b0; prev_tck = 1'b0; vbad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (a_busy) a_cmd_valid = 1'b0;
      if (a_tck && !prev_tck) nrise++;
      prev_tck = a_tck;
      if (nrise == 4 && a_tck) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (hit !== 1'b1) begin n_errors++; $display("FAIL abort_reach_bit3: got %b required 1", hit); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_tck, a_tms, a_tdi, a_busy, a_rsp_valid, a_cmd_ready, a_rsp_data} !== {6'b010000, 8'h00}) begin
      n_errors++; $display("FAIL abort_async: got %b required %b",
        {a_tck, a_tms, a_tdi, a_busy, a_rsp_valid, a_cmd_ready, a_rsp_data}, {6'b010000, 8'h00});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_rsp_valid || a_busy) vbad++;
    end
    a_rsp_ready = 1'b0;
    n_checks++;
    if (vbad !== 0) begin n_errors++; $display("FAIL abort_no_resp: got %0d bad cycles required 0", vbad); end
    run_cmd(8'($urandom), 3'd7, 1'b1, 1'b0, 8'($urandom), 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d [3];
    logic [2:0] l [3];
    logic [7:0] p [3];
    logic [7:0] mask;
    int n, nrise, last_rise, pbad, cyc;
    bit ok, seen;
    logic prev_tck;
    for (int k = 0; k < 3; k++) begin
      d[k] = 8'($urandom); l[k] = 3'($urandom); p[k] = 8'($urandom);
    end
    @(negedge clk);
    b_rsp_ready = 1'b1;
    b_cmd_data = d[0]; b_cmd_len = l[0]; b_cmd_tms = 1'b0; b_cmd_tms_last = 1'b1; b_cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (b_cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (ok !== 1'b1) begin n_errors++; $display("FAIL b2b_accept: got %b required 1", ok); end
    for (int k = 0; k < 3; k++) begin
      n = int'(l[k]) + 1;
      mask = 8'd0;
      for (int i = 0; i < n; i++) mask[i] = 1'b1;
      @(posedge clk); #1;
      if (k < 2) begin b_cmd_data = d[k+1]; b_cmd_len = l[k+1]; end
      else b_cmd_valid = 1'b0;
      nrise = 0; last_rise = -1; pbad = 0; seen = 1'b0; prev_tck = 1'b0;
      for (cyc = 1; cyc <= 100; cyc++) begin
        @(negedge clk);
        if (cyc == 1) begin
          n_checks++;
          if ({b_busy, b_tck} !== 2'b10) begin
            n_errors++; $display("FAIL b2b_start_low: busy/tck got %b required 10", {b_busy, b_tck});
          end
        end
        if (b_rsp_valid) begin seen = 1'b1; break; end
        if (b_tck && !prev_tck) begin
          if (last_rise >= 0 && cyc - last_rise != 2) pbad++;
          last_rise = cyc; nrise++;
        end
        if (!b_tck) b_tdo = (nrise < 8) ? p[k][nrise] : 1'b0;
        prev_tck = b_tck;
      end
      n_checks++;
      if (seen !== 1'b1) begin n_errors++; $display("FAIL b2b_rsp_timeout: got %b required 1", seen); end
      n_checks++;
      if (cyc !== 2 * n + 1) begin n_errors++; $display("FAIL b2b_cycles: got %0d required %0d", cyc - 1, 2 * n); end
      n_checks++;
      if (nrise !== n || pbad !== 0) begin
        n_errors++; $display("FAIL b2b_tck: pulses %0d bad periods %0d required %0d and 0", nrise, pbad, n);
      end
      n_checks++;
      if (b_rsp_data !== (p[k] & mask)) begin
        n_errors++; $display("FAIL b2b_rsp_data: got %h required %h", b_rsp_data, p[k] & mask);
      end
      @(negedge clk);
      n_checks++;
      if ({b_rsp_valid, b_busy, b_cmd_ready} !== 3'b001) begin
        n_errors++; $display("FAIL b2b_idle_gap: vld/busy/rdy got %b required 001", {b_rsp_valid, b_busy, b_cmd_ready});
      end
    end
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_cmd_valid = 1'b0; a_cmd_data = 8'h00; a_cmd_len = 3'd0; a_cmd_tms = 1'b0; a_cmd_tms_last = 1'b0;
    a_rsp_ready = 1'b0; a_tdo = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_data = 8'h00; b_cmd_len = 3'd0; b_cmd_tms = 1'b0; b_cmd_tms_last = 1'b0;
    b_rsp_ready = 1'b0; b_tdo = 1'b0;
    test_reset;
    test_loopback;
    test_single_bit;
    test_len2;
    test_random;
    test_rsp_hold;
    test_reset_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
